popcount_arbiter: RTL and testbench

Round-robin scheduler that shares one 8-bit ones-count datapath (two 4-bit half counters plus a 4-bit adder, result 0..8) between two requesters. Each requester offers an 8-bit word over a valid/ready handshake. The block grants one word per cycle, registers its ones count in a one-entry output buffer tagged with the requester ID, and presents it downstream over a valid/ready handshake. It sits between two producers of bit-vectors and any consumer of their population counts.

---
 rtl/popcount_arbiter_if.sv | 24 ++
 rtl/popcount_arbiter.sv | 136 +++++++++++++
 tb/tb_popcount_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/popcount_arbiter_if.sv
// popcount_arbiter_if: requester and result handshakes for popcount_arbiter.
// The slave modport is the arbiter's view of the bus; master is the producer/consumer side.
interface popcount_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       res_valid;
  logic [3:0] res_count;
  logic       res_id;
  logic       res_ready;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
    output req0_ready, req1_ready, res_valid, res_count, res_id
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, res_ready,
    input  req0_ready, req1_ready, res_valid, res_count, res_id
  );
endinterface

// File: rtl/popcount_arbiter.sv
// popcount_arbiter: two requesters share one 8-bit ones counter through a round-robin grant and a one-entry result buffer.
// Define POPCOUNT_ACC_EN to add per-requester saturating running totals (acc0, acc1, acc_clr).
module popcount_arbiter
`ifdef POPCOUNT_ACC_EN
  #(parameter int ACC_W = 12)
`endif
(
  input logic clk,
  input logic rst,
  popcount_arbiter_if.slave bus
`ifdef POPCOUNT_ACC_EN
  ,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc0,
  output logic [ACC_W-1:0] acc1
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       id_q, id_d;
  logic       last_q, last_d;

  logic       free;
  logic       grant0, grant1;
  logic       ready0, ready1;
  logic       accept0, accept1, accept;
  logic [7:0] sel_data;
  logic [2:0] lo_cnt, hi_cnt;
  logic [3:0] pop_sum;

  function automatic logic [2:0] nibble_ones(input logic [3:0] n);
    nibble_ones = {2'b00, n[0]} + {2'b00, n[1]} + {2'b00, n[2]} + {2'b00, n[3]};
  endfunction

  // When both requesters are valid, the one not served last wins the grant.
  always_comb begin
    grant0  = bus.req0_valid & (~bus.req1_valid | last_q);
    grant1  = bus.req1_valid & (~bus.req0_valid | ~last_q);
    free    = (state_q == EMPTY) | bus.res_ready;
    ready0  = ~rst & free & grant0;
    ready1  = ~rst & free & grant1;
    accept0 = bus.req0_valid & ready0;
    accept1 = bus.req1_valid & ready1;
    accept  = accept0 | accept1;
  end

  always_comb begin
    sel_data = accept1 ? bus.req1_data : bus.req0_data;
    lo_cnt   = nibble_ones(sel_data[3:0]);
    hi_cnt   = nibble_ones(sel_data[7:4]);
    pop_sum  = {1'b0, lo_cnt} + {1'b0, hi_cnt};
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    id_d    = id_q;
    last_d  = last_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)             state_d = FULL;
        else if (bus.res_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      count_d = pop_sum;
      id_d    = accept1;
      last_d  = accept1;
    end
  end

  // last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      count_q <= 4'd0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.res_valid  = (state_q == FULL);
  assign bus.res_count  = count_q;
  assign bus.res_id     = id_q;

`ifdef POPCOUNT_ACC_EN
  localparam int SUM_W = ACC_W + 4;

  logic [ACC_W-1:0] acc0_q, acc0_d;
  logic [ACC_W-1:0] acc1_q, acc1_d;
  logic [ACC_W-1:0] base0, base1;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [3:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({ACC_W{1'b1}})) sat_add = {ACC_W{1'b1}};
    else                           sat_add = s[ACC_W-1:0];
  endfunction

  // A clear coinciding with an accept restarts the granted total from this count.
  always_comb begin
    base0  = acc_clr ? '0 : acc0_q;
    base1  = acc_clr ? '0 : acc1_q;
    acc0_d = base0;
    acc1_d = base1;
    if (accept0) acc0_d = sat_add(base0, pop_sum);
    if (accept1) acc1_d = sat_add(base1, pop_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc0_q <= '0;
      acc1_q <= '0;
    end else begin
      acc0_q <= acc0_d;
      acc1_q <= acc1_d;
    end
  end

  assign acc0 = acc0_q;
  assign acc1 = acc1_q;
`endif

endmodule

// File: tb/tb_popcount_arbiter.sv
// tb_popcount_arbiter: scoreboard bench for popcount_arbiter with directed scenarios and a random phase.
// Build with POPCOUNT_ACC_EN defined to also check the running totals (ACC_W=4).
module tb_popcount_arbiter;
  localparam int ACC_W   = 4;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  typedef struct packed {
    logic [3:0] count;
    logic       id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  popcount_arbiter_if bus();

`ifdef POPCOUNT_ACC_EN
  logic [ACC_W-1:0] acc0, acc1;
  logic             acc_clr = 1'b0;
  popcount_arbiter #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .acc_clr(acc_clr), .acc0(acc0), .acc1(acc1)
  );
`else
  popcount_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  int   m_full = 0;
  bit   m_last = 1'b1;
  int   m_acc0 = 0;
  int   m_acc1 = 0;

  function automatic int ref_ones(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) if (d[i]) n++;
    return n;
  endfunction

  function automatic int sat(input int v);
    return (v > ACC_MAX) ? ACC_MAX : v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, checks readys and occupancy, then advances the model.
  task automatic applyStimulus(input bit r, input bit v0, input logic [7:0] d0,
                               input bit v1, input logic [7:0] d1,
                               input bit rr, input bit clr);
    bit g0, g1, e0, e1, fr;
    int cnt;
    @(negedge clk);
    rst            = r;
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
    bus.res_ready  = rr;
`ifdef POPCOUNT_ACC_EN
    acc_clr = clr;
`endif
    #1;
    checkOutput("res_valid", bus.res_valid, (m_full != 0));
`ifdef POPCOUNT_ACC_EN
    checkOutput("acc0", acc0, m_acc0);
    checkOutput("acc1", acc1, m_acc1);
`endif
    if (v0 && v1) begin
      g0 = (m_last == 1'b1);
      g1 = !g0;
    end else begin
      g0 = v0;
      g1 = v1;
    end
    fr = (m_full == 0) || rr;
    e0 = !r && fr && g0;
    e1 = !r && fr && g1;
    checkOutput("req0_ready", bus.req0_ready, e0);
    checkOutput("req1_ready", bus.req1_ready, e1);
    if (r) begin
      sb.delete();
      m_full = 0;
      m_last = 1'b1;
      m_acc0 = 0;
      m_acc1 = 0;
    end else begin
      if (clr) begin
        m_acc0 = 0;
        m_acc1 = 0;
      end
      if (e0 || e1) begin
        cnt = ref_ones(e1 ? d1 : d0);
        sb.push_back('{count: 4'(cnt), id: e1});
        m_last = e1;
        m_full = 1;
        if (e1) m_acc1 = sat(m_acc1 + cnt);
        else    m_acc0 = sat(m_acc0 + cnt);
      end else if (rr) begin
        m_full = 0;
      end
    end
  endtask

  // Monitor: whenever a result is drained, it must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL res_unexpected: got count %0d id %0d, required no result", bus.res_count, bus.res_id);
        end else begin
          e = sb.pop_front();
          checkOutput("res_count", bus.res_count, e.count);
          checkOutput("res_id", bus.res_id, e.id);
        end
      end
    end
  end

  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_data  = 8'h00;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 8'h00;
    bus.res_ready  = 1'b0;

    applyStimulus(1, 0, 8'h00, 0, 8'h00, 1, 0);
    applyStimulus(1, 0, 8'h00, 0, 8'h00, 1, 0);

    $display("[TB] single requester into empty buffer");
    applyStimulus(0, 1, 8'hFF, 0, 8'h00, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 0);

    $display("[TB] data edge values from requester 1");
    applyStimulus(0, 0, 8'h00, 1, 8'h00, 1, 0);
    applyStimulus(0, 0, 8'h00, 1, 8'hA5, 1, 0);
    applyStimulus(0, 0, 8'h00, 1, 8'h80, 1, 0);

    $display("[TB] sustained contention");
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'h0F, 1, 8'h01, 1, 0);

    $display("[TB] backpressure");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'h0F, 1, 8'h01, 0, 0);
    applyStimulus(0, 1, 8'h0F, 1, 8'h01, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 0);

    $display("[TB] reset mid-operation");
    applyStimulus(0, 0, 8'h00, 1, 8'h3C, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 8'h00, 0, 0);
    applyStimulus(0, 1, 8'h07, 1, 8'h77, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 0);

    $display("[TB] accumulator sequence");
    applyStimulus(1, 0, 8'h00, 0, 8'h00, 1, 0);
    applyStimulus(0, 1, 8'hFF, 0, 8'h00, 1, 0);
    applyStimulus(0, 1, 8'hFF, 0, 8'h00, 1, 0);
    applyStimulus(0, 1, 8'h03, 0, 8'h00, 1, 1);
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 3) != 0), 8'($urandom),
                    ($urandom_range(0, 3) != 0), 8'($urandom),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 19) == 0));
    end

    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 0);
    @(negedge clk);
    #3;
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
